// File: rtl/sdp_ram_axis_reader.sv
// sdp_ram_axis_reader
//   Reader end of the simple dual-port LUTRAM. A burst command (base address,
//   length minus one) is accepted in IDLE; the module then walks the RAM's
//   asynchronous read port one address per cycle and streams the words out on
//   an AXI-Stream master, holding the output word stable under backpressure.
//
// Ports
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   cmd_valid      burst command request
//   cmd_ready      high in IDLE; command taken on cmd_valid && cmd_ready
//   cmd_addr       first RAM address of the burst
//   cmd_len        burst length minus one (all ones = whole RAM)
//   rd_addr        RAM read address (combinational read)
//   rd_data        RAM read data for rd_addr, same cycle
//   m_axis_tdata   stream data
//   m_axis_tvalid  stream valid
//   m_axis_tready  stream ready
//   m_axis_tlast   high on the final word of a burst
//   busy           high whenever a burst is in progress

module sdp_ram_axis_reader #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [ADDR_WIDTH-1:0] cmd_len,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t state, state_next;

    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH-1:0] remaining;

    logic [DATA_WIDTH-1:0] tdata_p1;
    logic                  vld_p1;
    logic                  tlast_p1;

    logic cmd_fire;
    logic load;
    logic drain_done;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and control decode
    always_comb begin
        state_next = state;
        cmd_ready  = 1'b0;
        busy       = 1'b1;
        cmd_fire   = 1'b0;
        load       = 1'b0;
        drain_done = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) begin
                    cmd_fire   = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                // The output register can take a new word when it is empty
                // or its current word is being consumed this edge.
                if (!vld_p1 || m_axis_tready) begin
                    load = 1'b1;
                    if (remaining == '0) begin
                        state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (vld_p1 && m_axis_tready) begin
                    drain_done = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Stage p0 -> p1: RAM read data captured into the stream output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr    <= '0;
            remaining <= '0;
            tdata_p1  <= '0;
            vld_p1    <= 1'b0;
            tlast_p1  <= 1'b0;
        end else begin
            if (cmd_fire) begin
                rd_ptr    <= cmd_addr;
                remaining <= cmd_len;
            end
            if (load) begin
                tdata_p1  <= rd_data;
                vld_p1    <= 1'b1;
                tlast_p1  <= (remaining == '0);
                // Pointer wraps naturally at the top of the RAM.
                rd_ptr    <= rd_ptr + ADDR_WIDTH'(1);
                remaining <= remaining - ADDR_WIDTH'(1);
            end
            if (drain_done) begin
                vld_p1   <= 1'b0;
                tlast_p1 <= 1'b0;
            end
        end
    end

    assign rd_addr       = rd_ptr;
    assign m_axis_tdata  = tdata_p1;
    assign m_axis_tvalid = vld_p1;
    assign m_axis_tlast  = tlast_p1;

endmodule
